// File: rtl/imm_gen_if.sv
// rtl/imm_gen_if.sv - instruction in, decoded immediate and format out
interface imm_gen_if;
  logic [31:2] inst;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [31:0] imm_q;
  logic [2:0]  fmt_q;

  modport master (
    output inst,
    input  imm,
    input  fmt,
    input  imm_q,
    input  fmt_q
  );

  modport slave (
    input  inst,
    output imm,
    output fmt,
    output imm_q,
    output fmt_q
  );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate decoder with registered copy
module imm_gen (
  input  logic     clk,
  input  logic     rst,
  imm_gen_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  logic [31:2] inst;
  logic [2:0]  fmt;
  logic [31:0] imm;

  assign inst = bus.inst;

  // Format is chosen from the opcode alone; funct3/funct7 never matter.
  always_comb begin
    fmt = FMT_NONE;
    case (inst[6:2])
      5'b00100, 5'b00000, 5'b11001: fmt = FMT_I;
      5'b01000:                     fmt = FMT_S;
      5'b11000:                     fmt = FMT_B;
      5'b00101, 5'b01101:           fmt = FMT_U;
      5'b11011:                     fmt = FMT_J;
      5'b11100:                     fmt = FMT_Z;
      default:                      fmt = FMT_NONE;
    endcase
  end

  // Assemble the immediate for the selected format; shifts stay plain I.
  always_comb begin
    imm = 32'h0000_0000;
    case (fmt)
      FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'h000};
      FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z: imm = {27'h0, inst[19:15]};
      default: imm = 32'h0000_0000;
    endcase
  end

  assign bus.imm = imm;
  assign bus.fmt = fmt;

  // One-cycle registered copy; reset clears it and drops the pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.imm_q <= 32'h0000_0000;
      bus.fmt_q <= FMT_NONE;
    end else begin
      bus.imm_q <= imm;
      bus.fmt_q <= fmt;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - randomized and directed checks of imm_gen against a reference model
module tb_imm_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [2:0]  fmt_tab [32];
  logic [31:0] exp_q_imm;
  logic [2:0]  exp_q_fmt;

  imm_gen_if bus ();

  imm_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_fmt(input logic [31:2] i);
    logic [4:0] op;
    op = i[6:2];
    return fmt_tab[op];
  endfunction

  // Reference immediate built by arithmetic on the full 32-bit word.
  function automatic logic [31:0] ref_imm(input logic [31:2] i);
    logic [31:0]        w;
    logic signed [31:0] sw;
    logic [31:0]        sgn;
    w   = {i, 2'b11};
    sw  = w;
    sgn = 32'(sw >>> 31);
    case (ref_fmt(i))
      3'd1: return 32'(sw >>> 20);
      3'd2: return (32'(sw >>> 25) << 5) | 32'(w[11:7]);
      3'd3: return (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd4: return w & 32'hFFFF_F000;
      3'd5: return (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      3'd6: return (w >> 15) & 32'd31;
      default: return 32'h0;
    endcase
  endfunction

  // Apply one input at the falling edge, check the combinational path,
  // then check the registered path around the next rising edge.
  task automatic step(input string tag, input logic r, input logic [31:2] v,
                      input logic [31:0] e_imm, input logic [2:0] e_fmt);
    @(negedge clk);
    rst      = r;
    bus.inst = v;
    #1;
    check({tag, ".imm"}, bus.imm, e_imm);
    check({tag, ".fmt"}, 32'(bus.fmt), 32'(e_fmt));
    check({tag, ".imm_q_hold"}, bus.imm_q, exp_q_imm);
    exp_q_imm = r ? 32'h0 : e_imm;
    exp_q_fmt = r ? 3'd0 : e_fmt;
    @(posedge clk);
    #1;
    check({tag, ".imm_q"}, bus.imm_q, exp_q_imm);
    check({tag, ".fmt_q"}, 32'(bus.fmt_q), 32'(exp_q_fmt));
  endtask

  task automatic step_rand(input string tag, input logic r, input logic [31:2] v);
    step(tag, r, v, ref_imm(v), ref_fmt(v));
  endtask

  localparam logic [31:2] V_IM50  = 30'b111111001110_00001_000_01111_00100;
  localparam logic [31:2] V_LOAD  = 30'b000000001000_00010_010_01110_00000;
  localparam logic [31:2] V_JALR  = 30'b000000001000_00010_010_01110_11001;
  localparam logic [31:2] V_S     = 30'b0000000_01110_00010_010_01000_01000;
  localparam logic [31:2] V_B     = 30'b0_000000_01010_10011_000_1000_0_11000;
  localparam logic [31:2] V_BNEG  = {1'b1, 24'h0, 5'b11000};
  localparam logic [31:2] V_J     = 30'b0_1011011000_1_11110000_00101_11011;
  localparam logic [31:2] V_AUIPC = {20'b00000000010000001001, 5'b00000, 5'b00101};
  localparam logic [31:2] V_LUI   = {20'b00000000010000001001, 5'b00000, 5'b01101};
  localparam logic [31:2] V_Z7    = 30'b010000110101_00111_000_11000_11100;
  localparam logic [31:2] V_Z31   = {12'hFFF, 5'b11111, 3'b111, 5'b00000, 5'b11100};
  localparam logic [31:2] V_OP    = {25'h1FF_FFFF, 5'b01100};
  localparam logic [31:2] V_SRAI  = {7'b0100000, 5'b00011, 5'b00001, 3'b101, 5'b00010, 5'b00100};

  logic [4:0] ops [11];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_q_imm = 32'h0;
    exp_q_fmt = 3'd0;
    for (int k = 0; k < 32; k++) fmt_tab[k] = 3'd0;
    fmt_tab[5'b00100] = 3'd1;
    fmt_tab[5'b00000] = 3'd1;
    fmt_tab[5'b11001] = 3'd1;
    fmt_tab[5'b01000] = 3'd2;
    fmt_tab[5'b11000] = 3'd3;
    fmt_tab[5'b00101] = 3'd4;
    fmt_tab[5'b01101] = 3'd4;
    fmt_tab[5'b11011] = 3'd5;
    fmt_tab[5'b11100] = 3'd6;
    ops = '{5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000, 5'b00101,
            5'b01101, 5'b11011, 5'b11100, 5'b01100, 5'b00011};

    rst      = 1'b1;
    bus.inst = V_OP;
    @(posedge clk);
    #1;
    check("reset.imm_q", bus.imm_q, 32'h0);
    check("reset.fmt_q", 32'(bus.fmt_q), 32'd0);

    // Reset held two cycles: comb path follows inst, registers stay zero.
    step("rst_hold0", 1'b1, V_IM50, 32'hFFFF_FFCE, 3'd1);
    step("rst_hold1", 1'b1, V_S, 32'd8, 3'd2);
    step("rel_im50", 1'b0, V_IM50, 32'hFFFF_FFCE, 3'd1);
    step("rst_again", 1'b1, V_IM50, 32'hFFFF_FFCE, 3'd1);

    step("load", 1'b0, V_LOAD, 32'd8, 3'd1);
    step("jalr", 1'b0, V_JALR, 32'd8, 3'd1);
    step("store", 1'b0, V_S, 32'd8, 3'd2);
    step("branch", 1'b0, V_B, 32'd16, 3'd3);
    step("branch_neg", 1'b0, V_BNEG, 32'hFFFF_F000, 3'd3);
    step("jal", 1'b0, V_J, 32'b00000000000_0_11110000_1_1011011000_0, 3'd5);
    step("auipc", 1'b0, V_AUIPC, 32'h0040_9000, 3'd4);
    step("lui", 1'b0, V_LUI, 32'h0040_9000, 3'd4);
    step("csr7", 1'b0, V_Z7, 32'd7, 3'd6);
    step("csr31", 1'b0, V_Z31, 32'd31, 3'd6);
    step("op_none", 1'b0, V_OP, 32'h0, 3'd0);
    step("srai", 1'b0, V_SRAI, 32'h0000_0403, 3'd1);

    for (int n = 0; n < 300; n++) begin
      logic [31:2] v;
      logic        r;
      v = 30'($urandom);
      if ($urandom_range(0, 3) != 0) v[6:2] = ops[$urandom_range(0, 10)];
      r = ($urandom_range(0, 15) == 0);
      step_rand("rand", r, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 SHALL provide port: clk  input  1  single system clock; all registered state updates on its rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide port: inst  input  30 (bits [31:2])  instruction word with the two constant LSBs (2'b11) omitted; bit indices match the RV32I instruction word.
REQ-004 SHALL provide port: imm  output  32  combinational immediate decoded from the current inst.
REQ-005 SHALL provide port: fmt  output  3  combinational immediate-format code: 0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm), 7 unused.
REQ-006 SHALL provide port: imm_q  output  32  imm registered on clk.
REQ-007 SHALL provide port: fmt_q  output  3  fmt registered on clk.

Function
REQ-008 SHALL decode the format from opcode inst[6:2] only; funct3/funct7 SHALL NOT affect imm or fmt.
REQ-009 SHALL map opcodes: 00100 (OP-IMM), 00000 (LOAD), 11001 (JALR) -> I; 01000 (STORE) -> S; 11000 (BRANCH) -> B; 00101 (AUIPC), 01101 (LUI) -> U; 11011 (JAL) -> J; 11100 (SYSTEM/CSR) -> Z; all other opcodes -> none.
REQ-010 SHALL form I: sign-extend inst[31:20] to 32 bits.
REQ-011 SHALL form S: sign-extend {inst[31:25], inst[11:7]}.
REQ-012 SHALL form B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
REQ-013 SHALL form U: {inst[31:12], 12'b0}, no further extension.
REQ-014 SHALL form J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
REQ-015 SHALL form Z: zero-extend inst[19:15] (rs1 field) to 32 bits, for every funct3 of opcode 11100.
REQ-016 SHALL drive imm = 32'h0000_0000 when fmt = none (e.g. OP 01100, MISC-MEM 00011).
REQ-017 SHALL pass shift-immediate encodings (SLLI/SRLI/SRAI) as plain I-format; bit 10 of imm reflects inst[30]; no masking.
REQ-018 SHALL make imm and fmt purely combinational from inst, with zero clock latency and no dependence on clk or rst.
REQ-019 SHALL update imm_q <= imm and fmt_q <= fmt on every rising clk edge when rst = 0 (one-cycle latency, no enable, no stall).
REQ-020 SHALL contain no latches; every opcode value SHALL resolve to a defined imm and fmt.

Reset
REQ-021 SHALL, on a rising clk edge with rst = 1, set imm_q = 32'h0 and fmt_q = 3'd0 regardless of inst.
REQ-022 SHALL leave imm and fmt unaffected by rst; they track inst during and after reset.
REQ-023 SHALL resume capturing on the first rising edge with rst = 0; rst asserted mid-stream SHALL discard the pending value on that edge.

Verification
REQ-024 I-format: inst[31:2] = 111111001110_00001_000_01111_00100 -> imm = -50 (32'hFFFF_FFCE), fmt = 1; LOAD 000000001000_00010_010_01110_00000 and JALR ..._11001 with same imm field -> imm = 8.
REQ-025 S/B-format: inst = 0000000_01110_00010_010_01000_01000 -> imm = 8, fmt = 2; inst = 0_000000_01010_10011_000_1000_0_11000 -> imm = 16, fmt = 3; sign bit set (inst[31]=1, other imm bits 0) -> B imm = 32'hFFFF_F000.
REQ-026 J/U-format: inst = 0_1011011000_1_11110000_00101_11011 -> imm = {11'b0, 0_11110000_1_1011011000_0}, fmt = 5; upper field 00000000010000001001 with opcode 00101 or 01101 -> imm = 32'h0040_9000, fmt = 4.
REQ-027 Z-format: inst = 010000110101_00111_000_11000_11100 -> imm = 7, fmt = 6; rs1 field 11111 -> imm = 31 (no sign extension).
REQ-028 Default: opcode 01100 with all other bits 1 -> imm = 0, fmt = 0.
REQ-029 Registered path: hold rst = 1 two cycles -> imm_q = 0, fmt_q = 0 while imm follows inst; release rst, apply I-format -50 -> imm_q = 32'hFFFF_FFCE, fmt_q = 1 after exactly one rising edge; reassert rst -> imm_q = 0 after next edge.
